// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM: FSM encoding, depth rule and parity helper.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Widest word the parity helper accepts; callers zero-extend, which leaves XOR unchanged.
  localparam int PAR_MAX_W = 1024;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every address once after reset or on request, holding BUSY meanwhile.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // A request while already clearing is ignored since only IDLE looks at clr.
        if (clr) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/ram_dp_sync.sv
// Simple-dual-port synchronous RAM with registered read, RDW policy and hardware clear.
// Optional even parity per word when RAM_DP_SYNC_PARITY_EN is defined.
module ram_dp_sync
  import ram_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int WRITE_FIRST = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              RE,
  input  logic [ADDR_W-1:0] RA,
  input  logic              CLR,
  output logic [DATA_W-1:0] Q,
  output logic              RVALID,
  output logic              BUSY,
  output logic              PERR
);

  localparam int DEPTH = depth_of(ADDR_W);
`ifdef RAM_DP_SYNC_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [MW-1:0]     mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en, rd_acc, fwd, rd_perr;
  logic [ADDR_W-1:0] wr_addr;
  logic [MW-1:0]     wr_word, rd_word;

  ram_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (CLR),
    .busy     (BUSY),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

`ifdef RAM_DP_SYNC_PARITY_EN
  logic [PAR_MAX_W-1:0] wd_ext, rd_ext;
  always_comb begin
    wd_ext = '0;
    rd_ext = '0;
    wd_ext[DATA_W-1:0] = WD;
    rd_ext[DATA_W-1:0] = rd_word[DATA_W-1:0];
  end
  assign rd_perr = parity_of(rd_ext) != rd_word[DATA_W];
`else
  assign rd_perr = 1'b0;
`endif

  // The sequencer owns the write port while clearing; it always writes an all-zero word.
  always_comb begin
    wr_en   = BUSY ? clr_we   : WE;
    wr_addr = BUSY ? clr_addr : WA;
    wr_word = '0;
    if (!BUSY) begin
      wr_word[DATA_W-1:0] = WD;
`ifdef RAM_DP_SYNC_PARITY_EN
      wr_word[DATA_W] = parity_of(wd_ext);
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  assign rd_word = mem[RA];
  assign rd_acc  = RE && !BUSY;
  assign fwd     = (WRITE_FIRST != 0) && WE && (WA == RA);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q      <= '0;
      RVALID <= 1'b0;
      PERR   <= 1'b0;
    end else begin
      RVALID <= rd_acc;
      if (rd_acc) begin
        Q    <= fwd ? WD : rd_word[DATA_W-1:0];
        PERR <= fwd ? 1'b0 : rd_perr;
      end else begin
        PERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_sync.sv
// Directed bench for ram_dp_sync; a write-first and a read-first instance share stimulus.
module tb_ram_dp_sync;

  logic       CLK = 1'b0;
  logic       RST_N, WE, RE, CLR;
  logic [9:0] WA, RA;
  logic [7:0] WD;
  logic [7:0] q1, q0;
  logic       rv1, rv0, busy1, busy0, perr1, perr0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  ram_dp_sync #(.DATA_W(8), .ADDR_W(10), .WRITE_FIRST(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WA(WA), .WD(WD), .RE(RE), .RA(RA), .CLR(CLR),
    .Q(q1), .RVALID(rv1), .BUSY(busy1), .PERR(perr1)
  );

  ram_dp_sync #(.DATA_W(8), .ADDR_W(10), .WRITE_FIRST(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WA(WA), .WD(WD), .RE(RE), .RA(RA), .CLR(CLR),
    .Q(q0), .RVALID(rv0), .BUSY(busy0), .PERR(perr0)
  );

  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    WE = 1'b1; WA = a; WD = d;
    @(posedge CLK); #1;
    WE = 1'b0;
  endtask

  // Issues one read and returns at the following negedge with the result visible.
  task automatic do_read(input logic [9:0] a);
    RE = 1'b1; RA = a;
    @(posedge CLK); #1;
    RE = 1'b0;
    @(negedge CLK);
  endtask

  // Counts negedges with BUSY high; holds RE high and notes any RVALID seen meanwhile.
  task automatic count_busy(input int clr_at, output int n, output bit rv_seen);
    n = 0; rv_seen = 1'b0;
    RE = 1'b1; RA = 10'h001;
    @(negedge CLK);
    while (busy1 && n < 3000) begin
      n++;
      if (rv1 || rv0) rv_seen = 1'b1;
      CLR = (n == clr_at);
      @(negedge CLK);
    end
    RE = 1'b0; CLR = 1'b0;
  endtask

  task automatic test_reset;
    int n; bit rv;
    RST_N = 1'b0; WE = 0; RE = 0; CLR = 0; WA = 0; RA = 0; WD = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if ({q1, rv1, perr1, busy1} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reset_outputs got q=%h rv=%b perr=%b busy=%b", q1, rv1, perr1, busy1); end
    @(posedge CLK); #1; RST_N = 1'b1;
    count_busy(-1, n, rv);
    n_cmp++; if (n !== 1024) begin n_bad++; $display("FAIL reset_busy_len got %0d want 1024", n); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy0 got %b want 0", busy0); end
    do_read(10'h3FF);
    n_cmp++; if ({q1, rv1, q0, rv0} !== {8'h00, 1'b1, 8'h00, 1'b1}) begin
      n_bad++; $display("FAIL read_3ff got q=%h rv=%b q0=%h rv0=%b want 00/1", q1, rv1, q0, rv0); end
  endtask

  task automatic test_write_read;
    do_write(10'h005, 8'hA5);
    do_read(10'h005);
    n_cmp++; if ({q1, rv1, perr1} !== {8'hA5, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL wr_rd got q=%h rv=%b perr=%b want a5/1/0", q1, rv1, perr1); end
    @(negedge CLK);
    n_cmp++; if ({q1, rv1, q0, rv0} !== {8'hA5, 1'b0, 8'hA5, 1'b0}) begin
      n_bad++; $display("FAIL rd_hold got q=%h rv=%b q0=%h rv0=%b want a5/0", q1, rv1, q0, rv0); end
  endtask

  task automatic test_rdw;
    do_write(10'h010, 8'h11);
    WE = 1'b1; RE = 1'b1; WA = 10'h010; RA = 10'h010; WD = 8'h22;
    @(posedge CLK); #1; WE = 1'b0; RE = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({q1, rv1} !== {8'h22, 1'b1}) begin
      n_bad++; $display("FAIL rdw_write_first got %h/%b want 22/1", q1, rv1); end
    n_cmp++; if ({q0, rv0} !== {8'h11, 1'b1}) begin
      n_bad++; $display("FAIL rdw_read_first got %h/%b want 11/1", q0, rv0); end
    do_read(10'h010);
    n_cmp++; if ({q1, q0} !== {8'h22, 8'h22}) begin
      n_bad++; $display("FAIL rdw_after got %h/%h want 22/22", q1, q0); end
    // Different addresses in the same cycle do not interact.
    do_write(10'h041, 8'h66);
    WE = 1'b1; RE = 1'b1; WA = 10'h040; RA = 10'h041; WD = 8'h55;
    @(posedge CLK); #1; WE = 1'b0; RE = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({q1, q0} !== {8'h66, 8'h66}) begin
      n_bad++; $display("FAIL rdw_diff_addr got %h/%h want 66/66", q1, q0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [4];
    exp[0] = 8'h3C; exp[1] = 8'hC3; exp[2] = 8'h01; exp[3] = 8'h80;
    for (int i = 0; i < 4; i++) do_write(10'h030 + 10'(i), exp[i]);
    for (int i = 0; i < 4; i++) begin
      RE = 1'b1; RA = 10'h030 + 10'(i);
      @(posedge CLK); #1;
      @(negedge CLK);
      n_cmp++; if ({q1, rv1, q0, rv0} !== {exp[i], 1'b1, exp[i], 1'b1}) begin
        n_bad++; $display("FAIL b2b_%0d got %h/%b want %h/1", i, q1, rv1, exp[i]); end
    end
    RE = 1'b0;
  endtask

  task automatic test_clear;
    int n; bit rv;
    do_write(10'h001, 8'hFF);
    do_read(10'h001);
    n_cmp++; if (q1 !== 8'hFF) begin n_bad++; $display("FAIL clr_pre got %h want ff", q1); end
    CLR = 1'b1; @(posedge CLK); #1; CLR = 1'b0;
    // A second CLR at busy cycle 100 must not restart the sweep.
    count_busy(100, n, rv);
    n_cmp++; if (n !== 1024) begin n_bad++; $display("FAIL clr_busy_len got %0d want 1024", n); end
    n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL clr_rvalid_busy got %b want 0", rv); end
    n_cmp++; if ({q1, q0} !== {8'hFF, 8'hFF}) begin
      n_bad++; $display("FAIL clr_q_hold got %h/%h want ff/ff", q1, q0); end
    do_read(10'h001);
    n_cmp++; if ({q1, rv1, q0, rv0} !== {8'h00, 1'b1, 8'h00, 1'b1}) begin
      n_bad++; $display("FAIL clr_read got %h/%b want 00/1", q1, rv1); end
  endtask

  task automatic test_reset_mid;
    int n; bit rv;
    do_write(10'h005, 8'hA5);
    do_read(10'h005);
    CLR = 1'b1; @(posedge CLK); #1; CLR = 1'b0;
    repeat (500) @(negedge CLK);
    RST_N = 1'b0; #2;
    n_cmp++; if ({q1, rv1, perr1, busy1} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL mid_reset got q=%h rv=%b perr=%b busy=%b", q1, rv1, perr1, busy1); end
    @(posedge CLK); #1; RST_N = 1'b1;
    count_busy(-1, n, rv);
    n_cmp++; if (n !== 1024) begin n_bad++; $display("FAIL mid_busy_len got %0d want 1024", n); end
  endtask

  task automatic test_parity;
`ifdef RAM_DP_SYNC_PARITY_EN
    do_write(10'h020, 8'h3C);
    dut.mem[32][8] = ~dut.mem[32][8];
    do_read(10'h020);
    n_cmp++; if ({q1, rv1, perr1} !== {8'h3C, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL perr_flip got q=%h rv=%b perr=%b want 3c/1/1", q1, rv1, perr1); end
`endif
    do_write(10'h021, 8'h07);
    do_read(10'h021);
    n_cmp++; if ({q1, rv1, perr1} !== {8'h07, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL perr_clean got q=%h rv=%b perr=%b want 07/1/0", q1, rv1, perr1); end
    @(negedge CLK);
    n_cmp++; if ({rv1, perr1} !== 2'b00) begin
      n_bad++; $display("FAIL perr_idle got rv=%b perr=%b want 0/0", rv1, perr1); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_rdw;
    test_back_to_back;
    test_clear;
    test_reset_mid;
    test_parity;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_dp_sync.md
Name: ram_dp_sync

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, independent addresses. It is the next generation of the fixed 1024x8 register-file RAM used by the CPU datapath and memory subsystem. Additions over that design:
- registered read with a valid strobe
- defined read-during-write policy
- hardware clear sequencer that zeroes every word after reset or on request

Parameters:
DATA_W, 8, word width in bits (>=1)
ADDR_W, 10, address width; depth is 2**ADDR_W (derived, not a parameter)
WRITE_FIRST, 1, 1 = read of the word being written returns WD; 0 = returns old contents

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
WE  input  1  write enable
WA  input  ADDR_W  write address
WD  input  DATA_W  write data
RE  input  1  read enable
RA  input  ADDR_W  read address
CLR  input  1  request clear of the whole array (single-cycle pulse)
Q  output  DATA_W  registered read data
RVALID  output  1  Q updated this cycle from an accepted read
BUSY  output  1  clear sequence in progress; WE/RE ignored
PERR  output  1  parity error on current Q (see Optional Feature)

Behaviour:
- Reset (RST_N=0, asynchronous): Q=0, RVALID=0, PERR=0, BUSY=1, FSM=CLEAR, clear counter=0. Array contents are not asynchronously reset.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - One word written to zero per cycle at the counter address; counter increments.
  - After writing address 2**ADDR_W-1, next state is IDLE and BUSY drops on the same edge.
  - Total is 2**ADDR_W cycles after RST_N deasserts.
- IDLE: CLR=1 sends FSM to CLEAR with counter=0 and BUSY=1 on the next edge. CLR in CLEAR is ignored (no restart).
- Reset asserted mid-clear aborts the sequence; it restarts from 0 on release.
- While BUSY=1: WE and RE are ignored, RVALID=0, Q holds its value.
- Write (IDLE, WE=1): mem[WA] <= WD at the edge.
- Read (IDLE, RE=1):
  - Q <= mem[RA] and RVALID <= 1 at the edge (1-cycle latency).
  - RE=0: RVALID <= 0 and Q holds its last value.
  - RVALID is high exactly one cycle per accepted read. Back-to-back reads give one result per cycle.
- Read-during-write, same cycle with WE=RE=1 and WA==RA:
  - WRITE_FIRST=1: Q <= WD.
  - WRITE_FIRST=0: Q <= prior mem[RA].
  - Different addresses: no interaction.
- CLR and WE/RE in the same IDLE cycle: the write and read are performed; the clear starts on the next cycle.
- All address values are legal; there is no out-of-range case and no wrap logic beyond ADDR_W bits.

Optional Feature:
Macro RAM_DP_SYNC_PARITY_EN.
- Defined:
  - Each word stores DATA_W+1 bits, with the extra bit = XOR of the data (even parity). The clear sequencer writes parity 0.
  - On every accepted read, PERR <= (recomputed parity != stored bit), registered alongside Q/RVALID.
  - PERR is 0 when RVALID is 0.
  - On forwarding (WRITE_FIRST bypass), parity is computed from WD, so PERR is 0.
- Undefined: storage is DATA_W bits and PERR is tied to 0. The port is present either way so the interface is stable.

Decomposition:
- Shared package ram_pkg holds:
  - FSM state encoding (ST_CLEAR, ST_IDLE)
  - parity function
  - localparam rule depth = 1 << ADDR_W
- Natural sub-module: ram_clear_seq, containing the FSM, clear counter and BUSY. It outputs the clear write enable and address, which the top muxes onto the write port.

Test Plan:
- Reset release with defaults -> BUSY=1 for exactly 1024 cycles, then 0. Read of addr 0x3FF afterwards -> Q=0x00, RVALID=1 one cycle after RE.
- WE at WA=0x005, WD=0xA5, then RE at RA=0x005 -> Q=0xA5 with RVALID one cycle later. Hold RE=0 -> RVALID=0 and Q stays 0xA5.
- Same-cycle WE=RE=1, WA=RA=0x010, old=0x11, WD=0x22 -> Q=0x22 for WRITE_FIRST=1 and Q=0x11 for WRITE_FIRST=0. A subsequent read returns 0x22 in both cases.
- Write 0xFF to 0x001; pulse CLR -> BUSY=1 for 1024 cycles. RE during BUSY -> RVALID=0. Afterwards a read of 0x001 returns 0x00.
- RST_N pulsed low at clear cycle 500 -> outputs reset immediately, and BUSY stays high a full 1024 cycles from release.
- With RAM_DP_SYNC_PARITY_EN, force-flip the stored parity bit of 0x020 via hierarchical poke, then read -> PERR=1 with RVALID=1. A clean word read -> PERR=0.
